imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory.
- Receives a byte stream from a host link (UART RX or JTAG bridge) over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port at consecutive word-aligned byte addresses.
- Holds the core in reset until the full program is written, so firmware loads without regenerating the hex file.

---
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream from a host link and writes it into the
// instruction memory. The first little-endian 32-bit word is a header holding
// the word count N. The next N words go to byte addresses 0, 4, 8, and so on.
// The core is held in reset until the final word has been written.
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             core_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] words_loaded
);

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_FIN  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [1:0]       byte_idx_reg;
  logic [7:0]       lane_reg [3];
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             mem_we_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;

  logic             accept;
  logic             last_byte;
  logic [31:0]      word_full;

  // Ready depends only on the registered state.
  // There is no path from s_valid to s_ready.
  assign s_ready   = (state_reg == ST_HDR) || (state_reg == ST_DATA);
  assign accept    = s_valid && s_ready;
  assign last_byte = accept && (byte_idx_reg == 2'd3);
  // The fourth byte is combined with the three bytes already captured.
  // This forms the complete word in the same cycle the fourth byte arrives.
  assign word_full = {s_data, lane_reg[2], lane_reg[1], lane_reg[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      // Capture byte gi of the word being assembled.
      // This lane is independent of mem_wdata.
      always_ff @(posedge clk) begin
        if (rst)
          lane_reg[gi] <= '0;
        else if (accept && (byte_idx_reg == 2'(gi)))
          lane_reg[gi] <= s_data;
      end
    end
  endgenerate

  // Next-state logic.
  // A header above DEPTH goes to ERR, which also covers nonzero upper bits.
  // DONE and ERR are terminal until reset.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HDR: begin
        if (last_byte) begin
          if (word_full == 32'd0)
            state_next = ST_DONE;
          else if (word_full > 32'(DEPTH))
            state_next = ST_ERR;
          else
            state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (last_byte && ((cnt_reg + CNT_W'(1)) == n_reg))
          state_next = ST_FIN;
      end
      ST_FIN:  state_next = ST_DONE;
      ST_DONE: state_next = ST_DONE;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_HDR;
    endcase
  end

  // State register, byte index and latched word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_HDR;
      byte_idx_reg <= 2'd0;
      n_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (accept)
        byte_idx_reg <= byte_idx_reg + 2'd1;
      if ((state_reg == ST_HDR) && last_byte)
        n_reg <= word_full[CNT_W-1:0];
    end
  end

  // Memory write port.
  // The strobe lasts one cycle. Address and data are held between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      cnt_reg    <= '0;
    end else begin
      mem_we_reg <= 1'b0;
      if ((state_reg == ST_DATA) && last_byte) begin
        mem_we_reg <= 1'b1;
        wdata_reg  <= word_full;
        addr_reg   <= {{(30-CNT_W){1'b0}}, cnt_reg, 2'b00};
        cnt_reg    <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign mem_we       = mem_we_reg;
  assign mem_addr     = addr_reg;
  assign mem_wdata    = wdata_reg;
  assign words_loaded = cnt_reg;
  assign core_hold    = (state_reg != ST_DONE);
  assign load_done    = (state_reg == ST_DONE);
  assign load_err     = (state_reg == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random byte streams are scored against a
// reference model that expands each stream into its expected memory writes.
module tb_imem_loader;

  localparam int DEPTH = 1024;
  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = 8'h00;
  logic             s_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             core_hold;
  logic             load_done;
  logic             load_err;
  logic [CNT_W-1:0] words_loaded;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  logic [31:0] last_addr = 32'h0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [63:0] e;
      we_count++;
      last_addr = mem_addr;
      $display("write addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[63:32]));
        check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
      end
    end
  end

  // Reference model: the header gives N. Each complete group of four bytes
  // is a little-endian word written to address 4*i. Returns how many leading
  // bytes the loader should accept.
  function automatic int expect_stream(input logic [7:0] st[$]);
    logic [31:0] n;
    n = {st[3], st[2], st[1], st[0]};
    if (n == 32'd0 || n > 32'(DEPTH))
      return 4;
    for (int i = 0; i < int'(n); i++)
      exp_q.push_back({32'(4 * i), st[4*i+7], st[4*i+6], st[4*i+5], st[4*i+4]});
    return 4 + 4 * int'(n);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    we_count = 0;
  endtask

  task automatic check_reset();
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_core_hold", 64'(core_hold), 64'd1);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);
    check("rst_words_loaded", 64'(words_loaded), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Drive a byte after an optional random idle gap and wait until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int gap;
    int t;
    logic rdy;
    gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data = b;
    t = 0;
    rdy = 1'b0;
    while (!rdy && t < 100) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!rdy)
      check("byte_accept_timeout", 64'(rdy), 64'd1);
    s_valid = 1'b0;
  endtask

  // Offer a byte that must not be accepted.
  task automatic offer_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data = b;
    repeat (3) begin
      @(negedge clk);
      if (s_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("byte_rejected", 64'(acc), 64'd0);
  endtask

  task automatic run_stream(input logic [7:0] st[$], input int gapmax);
    int lim;
    lim = expect_stream(st);
    for (int i = 0; i < st.size(); i++) begin
      if (i < lim) send_byte(st[i], gapmax);
      else         offer_byte(st[i]);
    end
  endtask

  task automatic push_word(inout logic [7:0] st[$], input logic [31:0] w);
    st.push_back(w[7:0]);
    st.push_back(w[15:8]);
    st.push_back(w[23:16]);
    st.push_back(w[31:24]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] st[$];
    logic [31:0] w;
    int n;

    // Basic load, back-to-back bytes.
    do_reset();
    check_reset();
    st = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h04, 8'h53, 8'h00, 8'h33, 8'h05, 8'h73, 8'h40};
    run_stream(st, 0);
    @(negedge clk);
    check("t1_we_pulse", 64'(mem_we), 64'd1);
    check("t1_hold_during_write", 64'(core_hold), 64'd1);
    check("t1_done_early", 64'(load_done), 64'd0);
    @(negedge clk);
    check("t1_load_done", 64'(load_done), 64'd1);
    check("t1_core_hold", 64'(core_hold), 64'd0);
    check("t1_words", 64'(words_loaded), 64'd2);
    check("t1_we_count", 64'(we_count), 64'd2);
    check("t1_s_ready", 64'(s_ready), 64'd0);
    check("t1_addr_held", 64'(mem_addr), 64'h4);
    check("t1_data_held", 64'(mem_wdata), 64'h40730533);
    offer_byte(8'h5A);

    // Zero-length program.
    do_reset();
    st = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_stream(st, 0);
    @(negedge clk);
    check("t2_load_done", 64'(load_done), 64'd1);
    check("t2_core_hold", 64'(core_hold), 64'd0);
    check("t2_s_ready", 64'(s_ready), 64'd0);
    check("t2_we_count", 64'(we_count), 64'd0);
    offer_byte(8'hA5);

    // Oversize header counts: DEPTH+1, 65536, then a random oversize value.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      st.delete();
      if (k == 0)      w = 32'(DEPTH + 1);
      else if (k == 1) w = 32'h0001_0000;
      else             w = 32'(DEPTH + 1) + $urandom_range(32'h7fff_0000, 0);
      push_word(st, w);
      repeat (8) st.push_back(8'($urandom));
      run_stream(st, 2);
      @(negedge clk);
      check("t3_load_err", 64'(load_err), 64'd1);
      check("t3_core_hold", 64'(core_hold), 64'd1);
      check("t3_load_done", 64'(load_done), 64'd0);
      check("t3_s_ready", 64'(s_ready), 64'd0);
      check("t3_we_count", 64'(we_count), 64'd0);
    end

    // A gapped stream with N=1; no write may appear before the fourth byte.
    do_reset();
    st.delete();
    push_word(st, 32'd1);
    push_word(st, $urandom);
    void'(expect_stream(st));
    for (int i = 0; i < 7; i++) send_byte(st[i], 5);
    repeat (3) @(negedge clk);
    check("t4_no_early_write", 64'(we_count), 64'd0);
    @(posedge clk);
    #1;
    send_byte(st[7], 5);
    @(negedge clk);
    @(negedge clk);
    check("t4_we_count", 64'(we_count), 64'd1);
    check("t4_load_done", 64'(load_done), 64'd1);

    // Reset during a load, then a fresh load.
    do_reset();
    st.delete();
    push_word(st, 32'd3);
    repeat (3) push_word(st, $urandom);
    void'(expect_stream(st));
    for (int i = 0; i < 10; i++) send_byte(st[i], 1);
    @(negedge clk);
    check("t5_partial_writes", 64'(we_count), 64'd1);
    @(posedge clk);
    #1;
    do_reset();
    repeat (3) @(negedge clk);
    check("t5_no_write_after_rst", 64'(we_count), 64'd0);
    check_reset();
    st.delete();
    push_word(st, 32'd1);
    push_word(st, $urandom);
    run_stream(st, 2);
    @(negedge clk);
    @(negedge clk);
    check("t5_reload_addr", 64'(last_addr), 64'h0);
    check("t5_reload_words", 64'(words_loaded), 64'd1);
    check("t5_reload_done", 64'(load_done), 64'd1);

    // Random short loads.
    for (int k = 0; k < 5; k++) begin
      do_reset();
      st.delete();
      n = $urandom_range(8, 1);
      push_word(st, 32'(n));
      repeat (4 * n) st.push_back(8'($urandom));
      run_stream(st, $urandom_range(3, 0));
      @(negedge clk);
      @(negedge clk);
      check("rnd_words", 64'(words_loaded), 64'(n));
      check("rnd_pending", 64'(exp_q.size()), 64'd0);
      check("rnd_done", 64'(load_done), 64'd1);
    end

    // Full depth with incrementing words.
    do_reset();
    st.delete();
    push_word(st, 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) push_word(st, 32'h1000_0000 + 32'(i));
    run_stream(st, 0);
    @(negedge clk);
    @(negedge clk);
    check("t6_last_addr", 64'(last_addr), 64'hFFC);
    check("t6_words", 64'(words_loaded), 64'(DEPTH));
    check("t6_we_count", 64'(we_count), 64'(DEPTH));
    check("t6_load_done", 64'(load_done), 64'd1);
    check("t6_addr_held", 64'(mem_addr), 64'hFFC);
    check("t6_pending", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
